// File: rtl/step_datapath_if.sv
// step_datapath_if: instruction/status bundle between a step controller and step_datapath
// master drives the instruction fields and step pulse.
// slave (the datapath) returns reg_out, alu_out, n/z/c/v, busy and done.
interface step_datapath_if #(parameter int DW = 16, parameter int AW = 3);
  logic          i_step;
  logic          i_we;
  logic [AW-1:0] i_w_adr;
  logic [AW-1:0] i_r_adr;
  logic [AW-1:0] i_s_adr;
  logic          i_s_sel;
  logic [DW-1:0] i_ds;
  logic [3:0]    i_alu_op;
  logic [DW-1:0] o_reg_out;
  logic [DW-1:0] o_alu_out;
  logic          o_n;
  logic          o_z;
  logic          o_c;
  logic          o_v;
  logic          o_busy;
  logic          o_done;
  modport master (
    output i_step, i_we, i_w_adr, i_r_adr, i_s_adr, i_s_sel, i_ds, i_alu_op,
    input  o_reg_out, o_alu_out, o_n, o_z, o_c, o_v, o_busy, o_done
  );
  modport slave (
    input  i_step, i_we, i_w_adr, i_r_adr, i_s_adr, i_s_sel, i_ds, i_alu_op,
    output o_reg_out, o_alu_out, o_n, o_z, o_c, o_v, o_busy, o_done
  );
endinterface

// File: rtl/step_datapath.sv
// step_datapath: register file + ALU stepped through IDLE/LATCH/EXEC/WRITE per step pulse
// clk, reset : clock and synchronous active-high reset
// bus        : step_datapath_if slave (instruction in; reg_out, alu_out, flags, busy, done out)
module step_datapath #(parameter int DW = 16, parameter int AW = 3) (
  input logic          clk,
  input logic          reset,
  step_datapath_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LATCH, EXEC, WRITE} state_t;
  state_t        r_state;
  logic [DW-1:0] r_rf [2**AW];
  logic          r_we, r_s_sel;
  logic [AW-1:0] r_w_adr, r_r_adr, r_s_adr;
  logic [DW-1:0] r_ds, r_r, r_s, r_alu;
  logic [3:0]    r_op;
  logic          r_n, r_z, r_c, r_v, r_busy, r_done;
  logic [DW:0]   w_a, w_b, w_sum;
  logic          w_cin, w_ar, w_sc, w_cf, w_vf;
  logic [DW-1:0] w_res, w_alu;
  // Arithmetic ops share one DW+1 adder: a + b + cin, carry out in bit DW.
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_cin = 1'b0;
    w_ar = 1'b0;
    w_res = '0;
    w_sc = 1'b0;
    case (r_op)
      4'h0: w_res = r_r;
      4'h1: w_res = r_s;
      4'h2: {w_ar, w_a, w_cin} = {1'b1, 1'b0, r_s, 1'b1};
      4'h3: {w_ar, w_a, w_b} = {1'b1, 1'b0, r_s, 1'b0, {DW{1'b1}}};
      4'h4: {w_ar, w_a, w_b} = {1'b1, 1'b0, r_r, 1'b0, r_s};
      4'h5: {w_ar, w_a, w_b, w_cin} = {1'b1, 1'b0, r_r, 1'b0, ~r_s, 1'b1};
      4'h6: {w_sc, w_res} = {r_s, 1'b0};
      4'h7: {w_res, w_sc} = {1'b0, r_s};
      4'h8: w_res = r_r & r_s;
      4'h9: w_res = r_r | r_s;
      4'hA: w_res = r_r ^ r_s;
      4'hB: w_res = ~r_s;
      4'hC: {w_ar, w_b, w_cin} = {1'b1, 1'b0, ~r_s, 1'b1};
      4'hD: {w_res, w_sc} = {r_s[DW-1], r_s};
      default: w_res = '0;
    endcase
  end
  assign w_sum = w_a + w_b + (DW+1)'(w_cin);
  assign w_alu = w_ar ? w_sum[DW-1:0] : w_res;
  assign w_cf  = w_ar ? w_sum[DW] : w_sc;
  // Overflow: adder inputs share a sign that the result does not.
  assign w_vf  = w_ar & (w_a[DW-1] == w_b[DW-1]) & (w_sum[DW-1] != w_a[DW-1]);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      for (int i = 0; i < 2**AW; i++) r_rf[i] <= '0;
      {r_we, r_s_sel, r_w_adr, r_r_adr, r_s_adr, r_ds, r_op} <= '0;
      {r_r, r_s, r_alu, r_n, r_z, r_c, r_v, r_busy, r_done} <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.i_step) begin
          {r_we, r_s_sel, r_w_adr, r_r_adr, r_s_adr, r_ds, r_op} <=
            {bus.i_we, bus.i_s_sel, bus.i_w_adr, bus.i_r_adr, bus.i_s_adr, bus.i_ds, bus.i_alu_op};
          r_busy  <= 1'b1;
          r_state <= LATCH;
        end
        LATCH: begin
          r_r     <= r_rf[r_r_adr];
          r_s     <= r_s_sel ? r_ds : r_rf[r_s_adr];
          r_state <= EXEC;
        end
        EXEC: begin
          r_alu   <= w_alu;
          r_n     <= w_alu[DW-1];
          r_z     <= w_alu == '0;
          r_c     <= w_cf;
          r_v     <= w_vf;
          r_state <= WRITE;
        end
        WRITE: begin
          if (r_we) r_rf[r_w_adr] <= r_alu;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.o_reg_out = r_rf[bus.i_r_adr];
  assign bus.o_alu_out = r_alu;
  assign bus.o_n       = r_n;
  assign bus.o_z       = r_z;
  assign bus.o_c       = r_c;
  assign bus.o_v       = r_v;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
endmodule

// File: tb/tb_step_datapath.sv
// tb_step_datapath: scoreboard bench for step_datapath at DW=16/AW=3 and DW=8/AW=2
module tb_step_datapath;
  typedef struct {longint alu; logic [3:0] f;} exp_t;
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  int     errs = 0;
  int     checks = 0;
  int     nd;
  exp_t   sb[$];
  longint rf16[8];
  longint rf8[4];
  step_datapath_if #(.DW(16), .AW(3)) bus();
  step_datapath_if #(.DW(8), .AW(2)) bus8();
  step_datapath #(.DW(16), .AW(3)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  step_datapath #(.DW(8), .AW(2)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int dw, input int op, input longint r, input longint s);
    exp_t e;
    longint m, hb, full, rx, sx, sg;
    logic n, z, c, v;
    m = (longint'(1) << dw) - 1;
    hb = longint'(1) << (dw - 1);
    rx = (r & hb) != 0 ? r - (m + 1) : r;
    sx = (s & hb) != 0 ? s - (m + 1) : s;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: full = r;
      1: full = s;
      2: begin full = s + 1; c = s == m; v = s == hb - 1; end
      3: begin full = s - 1; c = s != 0; v = s == hb; end
      4: begin full = r + s; c = r + s > m; sg = rx + sx; v = sg > hb - 1 || sg < -hb; end
      5: begin full = r - s; c = r >= s; sg = rx - sx; v = sg > hb - 1 || sg < -hb; end
      6: begin full = s << 1; c = (s & hb) != 0; end
      7: begin full = s >> 1; c = (s & 1) != 0; end
      8: full = r & s;
      9: full = r | s;
      10: full = r ^ s;
      11: full = ~s;
      12: begin full = -s; c = s == 0; v = s == hb; end
      13: begin full = (s >> 1) | (s & hb); c = (s & 1) != 0; end
      default: full = 0;
    endcase
    e.alu = full & m;
    n = (e.alu & hb) != 0;
    z = e.alu == 0;
    e.f = {n, z, c, v};
    return e;
  endfunction
  function automatic longint alu_of(input bit b8);
    return b8 ? longint'(bus8.o_alu_out) : longint'(bus.o_alu_out);
  endfunction
  function automatic logic [3:0] flags_of(input bit b8);
    return b8 ? {bus8.o_n, bus8.o_z, bus8.o_c, bus8.o_v} : {bus.o_n, bus.o_z, bus.o_c, bus.o_v};
  endfunction
  function automatic logic busy_of(input bit b8);
    return b8 ? bus8.o_busy : bus.o_busy;
  endfunction
  function automatic logic done_of(input bit b8);
    return b8 ? bus8.o_done : bus.o_done;
  endfunction
  function automatic longint reg_of(input bit b8);
    return b8 ? longint'(bus8.o_reg_out) : longint'(bus.o_reg_out);
  endfunction
  task automatic drive(input bit b8, input bit st, input bit we, input int wa, input int ra,
                       input int sa, input bit ss, input longint ds, input int op);
    if (b8) begin
      bus8.i_step = st; bus8.i_we = we; bus8.i_w_adr = 2'(wa); bus8.i_r_adr = 2'(ra);
      bus8.i_s_adr = 2'(sa); bus8.i_s_sel = ss; bus8.i_ds = 8'(ds); bus8.i_alu_op = 4'(op);
    end else begin
      bus.i_step = st; bus.i_we = we; bus.i_w_adr = 3'(wa); bus.i_r_adr = 3'(ra);
      bus.i_s_adr = 3'(sa); bus.i_s_sel = ss; bus.i_ds = 16'(ds); bus.i_alu_op = 4'(op);
    end
  endtask
  task automatic wait_done(input bit b8);
    exp_t e;
    for (int k = 0; k < 8 && !done_of(b8); k++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", longint'(done_of(b8)), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("alu_out", alu_of(b8), e.alu);
      chk("nzcv", longint'(flags_of(b8)), longint'(e.f));
      chk("busy_clr", longint'(busy_of(b8)), 0);
    end
  endtask
  task automatic issue(input bit b8, input bit we, input int wa, input int ra, input int sa,
                       input bit ss, input longint ds, input int op);
    exp_t   e;
    longint r, s;
    int     dw;
    dw = b8 ? 8 : 16;
    r = b8 ? rf8[ra] : rf16[ra];
    s = ss ? ds & ((longint'(1) << dw) - 1) : (b8 ? rf8[sa] : rf16[sa]);
    e = model(dw, op, r, s);
    sb.push_back(e);
    if (we) begin
      if (b8) rf8[wa] = e.alu;
      else rf16[wa] = e.alu;
    end
    drive(b8, 1'b1, we, wa, ra, sa, ss, ds, op);
    @(posedge clk); #1;
    drive(b8, 1'b0, !we, int'($urandom_range(0, 7)), ra, int'($urandom_range(0, 7)), !ss, ~ds,
          int'($urandom_range(0, 15)));
    chk("busy_set", longint'(busy_of(b8)), 1);
    wait_done(b8);
    if (b8) bus8.i_r_adr = 2'(wa);
    else bus.i_r_adr = 3'(wa);
    #1;
    chk("reg_out", reg_of(b8), b8 ? rf8[wa] : rf16[wa]);
    @(posedge clk); #1;
    chk("done_pulse", longint'(done_of(b8)), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    foreach (rf16[i]) rf16[i] = 0;
    foreach (rf8[i]) rf8[i] = 0;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    bus.i_step = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.i_step = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.i_r_adr = 3'(i);
      #1 chk("rst_reg", reg_of(1'b0), 0);
    end
    chk("rst_alu", alu_of(1'b0), 0);
    chk("rst_flags", longint'(flags_of(1'b0)), 0);
    chk("rst_busy", longint'(busy_of(1'b0)), 0);
    chk("rst_done", longint'(done_of(1'b0)), 0);
    issue(1'b0, 1'b1, 1, 0, 0, 1'b1, 'hAA55, 1);
    issue(1'b0, 1'b1, 2, 1, 0, 1'b1, 'h55AB, 4);
    issue(1'b0, 1'b0, 3, 0, 0, 1'b1, 'h7FFF, 2);
    issue(1'b0, 1'b1, 3, 2, 0, 1'b1, 'h0001, 5);
    issue(1'b0, 1'b0, 0, 0, 0, 1'b1, 'h8000, 12);
    issue(1'b0, 1'b0, 0, 0, 0, 1'b1, 'h0000, 3);
    issue(1'b0, 1'b1, 3, 3, 3, 1'b0, 0, 4);
    repeat (30) issue(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), longint'($urandom_range(0, 'hFFFF)),
                      int'($urandom_range(0, 15)));
    sb.push_back(model(16, 1, rf16[0], 'h1234));
    rf16[4] = 'h1234;
    drive(1'b0, 1'b1, 1'b1, 4, 0, 0, 1'b1, 'h1234, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 5, 0, 0, 1'b1, 'h5555, 1);
    @(posedge clk); #1;
    bus.i_step = 1'b0;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_done) begin
        nd++;
        if (sb.size() > 0) chk("busy_alu", alu_of(1'b0), sb.pop_front().alu);
      end
      @(posedge clk); #1;
    end
    chk("one_done", nd, 1);
    bus.i_r_adr = 3'd4;
    #1 chk("busy_r4", reg_of(1'b0), rf16[4]);
    bus.i_r_adr = 3'd5;
    #1 chk("busy_r5", reg_of(1'b0), rf16[5]);
    drive(1'b0, 1'b1, 1'b1, 6, 0, 0, 1'b1, 'hBEEF, 1);
    @(posedge clk); #1;
    bus.i_step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    foreach (rf16[i]) rf16[i] = 0;
    foreach (rf8[i]) rf8[i] = 0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.o_done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_done", nd, 0);
    bus.i_r_adr = 3'd6;
    #1 chk("abort_reg", reg_of(1'b0), 0);
    chk("abort_alu", alu_of(1'b0), 0);
    chk("abort_busy", longint'(busy_of(1'b0)), 0);
    issue(1'b1, 1'b1, 1, 0, 0, 1'b1, 'h80, 6);
    issue(1'b1, 1'b1, 2, 0, 0, 1'b1, 'h80, 13);
    repeat (12) issue(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), longint'($urandom_range(0, 'hFF)),
                      int'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/step_datapath.md
STEP_DATAPATH -- requirements
Module: step_datapath

Interface
REQ-001 Parameter DW, default 16, data width of registers, operands, ALU result.
REQ-002 Parameter AW, default 3, register-file address width; register count is 2**AW.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 step  input  1  single-cycle start pulse (from debounce one-shot).
REQ-006 we  input  1  write-back enable for the instruction.
REQ-007 w_adr / r_adr / s_adr  input  AW each  destination, R-operand, S-operand addresses.
REQ-008 s_sel  input  1  S-operand select: 0 = RF[s_adr], 1 = ds.
REQ-009 ds  input  DW  external data operand.
REQ-010 alu_op  input  4  operation code (REQ-020).
REQ-011 reg_out  output  DW  combinational read of RF[r_adr] (live r_adr, not latched).
REQ-012 alu_out  output  DW  registered ALU result of last completed EXEC.
REQ-013 n, z, c, v  output  1 each  registered negative, zero, carry, overflow flags.
REQ-014 busy  output  1  high while an instruction is in flight.
REQ-015 done  output  1  one-cycle pulse after write-back completes.

Function
REQ-016 FSM states IDLE, LATCH, EXEC, WRITE; IDLE->LATCH on step, LATCH->EXEC->WRITE->IDLE unconditionally.
REQ-017 On step in IDLE: we, w_adr, r_adr, s_adr, s_sel, ds, alu_op captured into instruction register; later input changes have no effect on that instruction.
REQ-018 LATCH: operand registers loaded with R = RF[r_adr_q], S = s_sel_q ? ds_q : RF[s_adr_q].
REQ-019 EXEC: alu_out and n, z, c, v updated together from latched operands.
REQ-020 Ops: 0 R; 1 S; 2 S+1; 3 S-1; 4 R+S; 5 R-S; 6 S<<1; 7 S>>1 logical; 8 R&S; 9 R|S; A R^S; B ~S; C -S; D S>>>1 arithmetic; E,F zero.
REQ-021 Arithmetic in DW+1 bits; subtraction as R+~S+1 (dec: S+all-ones); c = bit DW (1 = no borrow on sub/dec).
REQ-022 c for shifts = bit shifted out; c = 0 for all other ops.
REQ-023 v = signed overflow for ops 2,3,4,5,C (neg of most-negative sets v=1); v = 0 otherwise.
REQ-024 n = alu_out[DW-1]; z = (alu_out == 0); both computed for every op.
REQ-025 WRITE: if we_q, RF[w_adr_q] <= alu_out at end of WRITE cycle; if not, RF unchanged.
REQ-026 busy = 1 in LATCH, EXEC, WRITE; 0 in IDLE.
REQ-027 done = 1 for exactly the first IDLE cycle after WRITE.
REQ-028 Latency: step sampled at edge t -> alu_out/flags valid after edge t+2, RF written at edge t+3, done high cycle t+3..t+4.
REQ-029 step while busy is ignored, not queued; step coincident with done cycle starts a new instruction.
REQ-030 Write to register addressed by r_adr visible on reg_out in cycle after write edge.
REQ-031 w_adr equal to r_adr_q or s_adr_q: operands already latched, old value used.

Reset
REQ-032 Reset: state IDLE, all RF entries, operand/instruction registers, alu_out, n, z, c, v, busy, done cleared to 0.
REQ-033 Reset overrides step in same cycle; reset in any non-IDLE state aborts with no RF write and no done pulse.

Verification
REQ-034 Reset, step held low 10 cycles -> reg_out=0 for all r_adr, alu_out=0, n=z=c=v=0, busy=0.
REQ-035 ds=AA55, s_sel=1, op=1, w_adr=1, we=1, step -> alu_out=AA55, n=1, z=0; r_adr=1 reg_out=AA55 after edge t+3; done one cycle.
REQ-036 R1=AA55, ds=55AB, s_sel=1, op=4, w_adr=2 -> alu_out=0000, z=1, c=1, v=0, n=0; R2=0000.
REQ-037 ds=7FFF, op=2 -> 8000, n=1, v=1, c=0; op=5 with R=0000, S=0001 -> FFFF, c=0, n=1.
REQ-038 Second step during busy -> ignored, one done only; reset asserted in EXEC -> target register still 0, no done.
REQ-039 DW=8, AW=2 build: ds=80, op=6 -> alu_out=00, c=1, z=1; op=D on 80 -> C0, c=0, n=1.
